transposer_job_sched: RTL and testbench

Job scheduler for the per-MVU data transposers. It accepts transposer jobs (target MVU, precision, base address, input word) from the controller side through a valid/ready port, queues them in a shared in-order FIFO, and dispatches each job as a one-cycle `mvu_data_start` pulse with its fields. It tracks each MVU's `mvu_data_busy` so a transposer never receives a new job while one is in flight. It sits between PITO-side control and the `mvu_data_*` bundle of the BARVINN system interface.

---
 rtl/transposer_job_sched.sv | 142 ++++++++++++++
 tb/tb_transposer_job_sched.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/transposer_job_sched.sv
// transposer_job_sched: in-order job FIFO that dispatches transposer jobs to
// per-MVU data ports. It holds back a job whose target MVU still has a job in
// flight. Completion is detected when the MVU's busy signal has been seen
// high and then falls.
module transposer_job_sched #(
  parameter  int NMVU  = 8,
  parameter  int XLEN  = 32,
  parameter  int DEPTH = 4,
  localparam int MW    = $clog2(NMVU),
  localparam int AW    = $clog2(DEPTH),
  localparam int PW    = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 job_valid,
  output logic                 job_ready,
  input  logic [MW-1:0]        job_mvu,
  input  logic [31:0]          job_prec,
  input  logic [31:0]          job_baddr,
  input  logic [XLEN-1:0]      job_iword,
  output logic [NMVU*32-1:0]   mvu_data_prec,
  output logic [NMVU*32-1:0]   mvu_data_baddr,
  output logic [NMVU*XLEN-1:0] mvu_data_iword,
  output logic [NMVU-1:0]      mvu_data_start,
  input  logic [NMVU-1:0]      mvu_data_busy,
  output logic [NMVU-1:0]      job_done,
  output logic [PW-1:0]        pending,
  output logic                 sched_idle,
  output logic                 err_bad_mvu
);

  // Job storage. Only pointers and occupancy need reset; entry contents are
  // don't-care until written.
  logic [MW-1:0]   fifo_mvu   [DEPTH];
  logic [31:0]     fifo_prec  [DEPTH];
  logic [31:0]     fifo_baddr [DEPTH];
  logic [XLEN-1:0] fifo_iword [DEPTH];

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [PW-1:0] pending_reg;
  logic          err_reg;
  logic [NMVU-1:0] inflight;

  logic          accept;
  logic          bad_mvu;
  logic          push;
  logic          pop;
  logic [MW-1:0] head_mvu;

  // A job targeting a non-existent MVU is consumed but never stored.
  assign bad_mvu   = ({1'b0, job_mvu} >= (MW+1)'(NMVU));
  assign job_ready = rst_n && (pending_reg < PW'(DEPTH));
  assign accept    = job_valid && job_ready;
  assign push      = accept && !bad_mvu;
  assign head_mvu  = fifo_mvu[rd_ptr_reg];
  // Strict in-order issue: only the head may dispatch.
  assign pop       = (pending_reg != '0) && !inflight[head_mvu];

  assign pending     = pending_reg;
  assign err_bad_mvu = err_reg;
  assign sched_idle  = (pending_reg == '0) && (inflight == '0);

  // Write the accepted job into the slot at the write pointer.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mvu[wr_ptr_reg]   <= job_mvu;
      fifo_prec[wr_ptr_reg]  <= job_prec;
      fifo_baddr[wr_ptr_reg] <= job_baddr;
      fifo_iword[wr_ptr_reg] <= job_iword;
    end
  end

  // Pointers, occupancy and the sticky bad-MVU flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      pending_reg <= '0;
      err_reg     <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push && !pop)      pending_reg <= pending_reg + 1'b1;
      else if (pop && !push) pending_reg <= pending_reg - 1'b1;
      if (accept && bad_mvu) err_reg <= 1'b1;
    end
  end

  // One tracking/output slice per MVU.
  for (genvar gi = 0; gi < NMVU; gi++) begin : g_mvu
    logic            dispatch;
    logic            inflight_reg;
    logic            seen_busy_reg;
    logic            start_reg;
    logic            done_reg;
    logic [31:0]     prec_reg;
    logic [31:0]     baddr_reg;
    logic [XLEN-1:0] iword_reg;

    assign dispatch = pop && (head_mvu == MW'(gi));

    // Load fields and pulse start on dispatch; track busy rise/fall afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        inflight_reg  <= 1'b0;
        seen_busy_reg <= 1'b0;
        start_reg     <= 1'b0;
        done_reg      <= 1'b0;
        prec_reg      <= '0;
        baddr_reg     <= '0;
        iword_reg     <= '0;
      end else begin
        start_reg <= dispatch;
        done_reg  <= 1'b0;
        if (dispatch) begin
          prec_reg      <= fifo_prec[rd_ptr_reg];
          baddr_reg     <= fifo_baddr[rd_ptr_reg];
          iword_reg     <= fifo_iword[rd_ptr_reg];
          inflight_reg  <= 1'b1;
          seen_busy_reg <= 1'b0;
        end else if (inflight_reg) begin
          if (seen_busy_reg && !mvu_data_busy[gi]) begin
            inflight_reg  <= 1'b0;
            seen_busy_reg <= 1'b0;
            done_reg      <= 1'b1;
          end else if (mvu_data_busy[gi]) begin
            seen_busy_reg <= 1'b1;
          end
        end
      end
    end

    assign inflight[gi]                     = inflight_reg;
    assign mvu_data_start[gi]               = start_reg;
    assign job_done[gi]                     = done_reg;
    assign mvu_data_prec[gi*32 +: 32]       = prec_reg;
    assign mvu_data_baddr[gi*32 +: 32]      = baddr_reg;
    assign mvu_data_iword[gi*XLEN +: XLEN]  = iword_reg;
  end

endmodule

// File: tb/tb_transposer_job_sched.sv
// Directed bench for transposer_job_sched. Inputs are driven and outputs
// sampled on the falling clock edge. A second instance with six MVUs covers
// the out-of-range MVU index case, which cannot be expressed with eight.
module tb_transposer_job_sched;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         job_valid;
  logic         job_ready;
  logic [2:0]   job_mvu;
  logic [31:0]  job_prec;
  logic [31:0]  job_baddr;
  logic [31:0]  job_iword;
  logic [255:0] prec_bus;
  logic [255:0] baddr_bus;
  logic [255:0] iword_bus;
  logic [7:0]   start;
  logic [7:0]   busy;
  logic [7:0]   done;
  logic [2:0]   pending;
  logic         sched_idle;
  logic         err_bad;

  logic         b_valid;
  logic         b_ready;
  logic [2:0]   b_mvu;
  logic [191:0] b_prec_bus;
  logic [191:0] b_baddr_bus;
  logic [191:0] b_iword_bus;
  logic [5:0]   b_start;
  logic [5:0]   b_busy;
  logic [5:0]   b_done;
  logic [2:0]   b_pending;
  logic         b_idle;
  logic         b_err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_cnt  [8];
  int last_start [8];
  int m_cyc;

  transposer_job_sched dut (
    .clk(clk), .rst_n(rst_n), .job_valid(job_valid), .job_ready(job_ready),
    .job_mvu(job_mvu), .job_prec(job_prec), .job_baddr(job_baddr),
    .job_iword(job_iword), .mvu_data_prec(prec_bus), .mvu_data_baddr(baddr_bus),
    .mvu_data_iword(iword_bus), .mvu_data_start(start), .mvu_data_busy(busy),
    .job_done(done), .pending(pending), .sched_idle(sched_idle),
    .err_bad_mvu(err_bad)
  );

  transposer_job_sched #(.NMVU(6)) dut_b (
    .clk(clk), .rst_n(rst_n), .job_valid(b_valid), .job_ready(b_ready),
    .job_mvu(b_mvu), .job_prec(job_prec), .job_baddr(job_baddr),
    .job_iword(job_iword), .mvu_data_prec(b_prec_bus), .mvu_data_baddr(b_baddr_bus),
    .mvu_data_iword(b_iword_bus), .mvu_data_start(b_start), .mvu_data_busy(b_busy),
    .job_done(b_done), .pending(b_pending), .sched_idle(b_idle),
    .err_bad_mvu(b_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record when each start pulse is seen, in bench cycle numbers.
  always @(negedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (start[i]) begin
        start_cnt[i]  = start_cnt[i] + 1;
        last_start[i] = cyc;
      end
    end
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  function automatic logic [255:0] sl(input int idx, input logic [31:0] v);
    logic [255:0] r;
    r = '0;
    r[idx*32 +: 32] = v;
    return r;
  endfunction

  // Offer one job and hold it until accepted; returns one cycle after acceptance.
  task automatic send(input logic [2:0] m, input logic [31:0] p, input logic [31:0] b,
                      input logic [31:0] w);
    int waited;
    job_valid = 1'b1; job_mvu = m; job_prec = p; job_baddr = b; job_iword = w;
    waited = 0;
    while (!job_ready && waited < 100) begin
      tick();
      waited++;
    end
    if (!job_ready) check("send_timeout", 256'(job_ready), 256'd1);
    tick();
    job_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin start_cnt[i] = 0; last_start[i] = -1; end
    rst_n = 1'b0; job_valid = 1'b0; job_mvu = '0; job_prec = '0; job_baddr = '0;
    job_iword = '0; busy = '0; b_valid = 1'b0; b_mvu = '0; b_busy = '0;

    // Reset state
    tick(2);
    check("rst_start", 256'(start), 256'd0);
    check("rst_done", 256'(done), 256'd0);
    check("rst_pending", 256'(pending), 256'd0);
    check("rst_idle", 256'(sched_idle), 256'd1);
    check("rst_ready", 256'(job_ready), 256'd0);
    check("rst_err", 256'(err_bad), 256'd0);
    check("rst_prec", prec_bus, 256'd0);
    rst_n = 1'b1;
    tick();
    check("ready_after_rst", 256'(job_ready), 256'd1);

    // Single job to MVU 2: start two cycles after acceptance
    send(3'd2, 32'h0000_0202, 32'h40, 32'hDEAD_BEEF);
    check("j1_start_n1", 256'(start), 256'd0);
    tick();
    check("j1_start_n2", 256'(start), 256'b0000_0100);
    check("j1_prec", prec_bus, sl(2, 32'h0000_0202));
    check("j1_baddr", baddr_bus, sl(2, 32'h40));
    check("j1_iword", iword_bus, sl(2, 32'hDEAD_BEEF));
    tick();
    check("j1_start_n3", 256'(start), 256'd0);
    check("j1_prec_hold", prec_bus, sl(2, 32'h0000_0202));
    check("j1_busy_idle", 256'(sched_idle), 256'd0);

    // Busy[2] for 10 cycles, then completion
    busy[2] = 1'b1;
    tick(10);
    busy[2] = 1'b0;
    check("j1_done_m", 256'(done), 256'd0);
    tick();
    check("j1_done_m1", 256'(done), 256'b0000_0100);
    tick();
    check("j1_done_m2", 256'(done), 256'd0);
    check("j1_idle", 256'(sched_idle), 256'd1);

    // Two jobs to MVU 3 then one to MVU 5: head-of-line blocking
    send(3'd3, 32'h31, 32'h310, 32'h3100);
    send(3'd3, 32'h32, 32'h320, 32'h3200);
    send(3'd5, 32'h51, 32'h510, 32'h5100);
    tick(3);
    check("hol_start3_cnt", 256'(start_cnt[3]), 256'd1);
    check("hol_start5_blocked", 256'(start_cnt[5]), 256'd0);
    check("hol_pending", 256'(pending), 256'd2);
    busy[3] = 1'b1;
    tick(3);
    busy[3] = 1'b0;
    m_cyc = cyc;
    tick(5);
    check("hol_start3_cnt2", 256'(start_cnt[3]), 256'd2);
    check("hol_start3_time", 256'(last_start[3] - m_cyc), 256'd2);
    check("hol_start5_time", 256'(last_start[5] - m_cyc), 256'd3);
    check("hol_prec", prec_bus, sl(2, 32'h202) | sl(3, 32'h32) | sl(5, 32'h51));
    busy[3] = 1'b1; busy[5] = 1'b1;
    tick(2);
    busy = '0;
    tick(3);
    check("hol_idle", 256'(sched_idle), 256'd1);

    // Fill the FIFO behind a busy-held MVU 0
    busy[0] = 1'b1;
    for (int k = 0; k < 5; k++) send(3'd0, 32'h100 + k, 32'h0, 32'h0);
    check("full_pending", 256'(pending), 256'd4);
    check("full_ready", 256'(job_ready), 256'd0);
    job_valid = 1'b1; job_mvu = 3'd1;
    tick(2);
    job_valid = 1'b0;
    check("full_no_accept", 256'(pending), 256'd4);
    for (int k = 0; k < 4; k++) begin
      busy[0] = 1'b0;
      tick();
      check($sformatf("drain%0d_done", k), 256'(done[0]), 256'd1);
      if (k == 0) check("drain_ready_m1", 256'(job_ready), 256'd0);
      tick();
      check($sformatf("drain%0d_start", k), 256'(start), 256'd1);
      check($sformatf("drain%0d_pending", k), 256'(pending), 256'(3 - k));
      check($sformatf("drain%0d_prec", k), 256'(prec_bus[31:0]), 256'(32'h101 + k));
      if (k == 0) check("drain_ready", 256'(job_ready), 256'd1);
      busy[0] = 1'b1;
      tick();
    end
    busy[0] = 1'b0;
    tick(2);
    check("drain_idle", 256'(sched_idle), 256'd1);

    // Out-of-range MVU on the six-MVU instance
    check("bad_err_init", 256'(b_err), 256'd0);
    b_valid = 1'b1; b_mvu = 3'd7;
    tick();
    b_valid = 1'b0;
    check("bad_err_set", 256'(b_err), 256'd1);
    check("bad_pending", 256'(b_pending), 256'd0);
    tick(3);
    check("bad_no_start", 256'(b_start), 256'd0);
    check("bad_idle", 256'(b_idle), 256'd1);
    b_valid = 1'b1; b_mvu = 3'd4;
    tick();
    b_valid = 1'b0;
    tick();
    check("bad_good_start", 256'(b_start), 256'b01_0000);
    check("bad_err_sticky", 256'(b_err), 256'd1);

    // Asynchronous reset with 2 jobs in flight and 3 queued
    send(3'd1, 32'hA1, 32'hB1, 32'hC1);
    send(3'd4, 32'hA4, 32'hB4, 32'hC4);
    send(3'd1, 32'hA2, 32'hB2, 32'hC2);
    send(3'd1, 32'hA3, 32'hB3, 32'hC3);
    send(3'd1, 32'hA5, 32'hB5, 32'hC5);
    tick(2);
    check("ar_pending", 256'(pending), 256'd3);
    check("ar_baddr", baddr_bus[191:0], 192'(sl(1, 32'hB1) | sl(4, 32'hB4) | sl(2, 32'h40)
                                             | sl(3, 32'h320) | sl(5, 32'h510)));
    #2 rst_n = 1'b0;
    #1;
    check("ar_now_pending", 256'(pending), 256'd0);
    check("ar_now_baddr", baddr_bus, 256'd0);
    check("ar_now_ready", 256'(job_ready), 256'd0);
    check("ar_now_idle", 256'(sched_idle), 256'd1);
    check("ar_now_err", 256'(b_err), 256'd0);
    tick(2);
    rst_n = 1'b1;
    tick();
    check("ar_rel_idle", 256'(sched_idle), 256'd1);
    check("ar_rel_pending", 256'(pending), 256'd0);
    send(3'd1, 32'hEE, 32'hEE, 32'hEE);
    tick();
    check("ar_rel_start", 256'(start), 256'b0000_0010);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
